// File: rtl/cmd_scheduler_if.sv
// ----------------------------------------------------------------------------
// cmd_scheduler_if
// Bundles the button, UART and command-pulse signals of cmd_scheduler.
//   slave  : the scheduler side (buttons/UART in, pulses/echo/status out)
//   master : the environment side (drives buttons/UART, observes outputs)
// Signals:
//   i_btn_run, i_btn_clear, i_btn_mode : single-cycle button events
//   rx_data[7:0], rx_done              : received UART byte and its strobe
//   tx_busy                            : UART transmitter busy
//   o_run_toggle, o_clear, o_mode_toggle : single-cycle command pulses
//   tx_data[7:0], tx_start             : echo byte and send request
//   o_fifo_full                        : command queue full
//   o_drop_cnt[7:0]                    : saturating dropped-event count
// ----------------------------------------------------------------------------
interface cmd_scheduler_if;
    logic       i_btn_run;
    logic       i_btn_clear;
    logic       i_btn_mode;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic       o_run_toggle;
    logic       o_clear;
    logic       o_mode_toggle;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       o_fifo_full;
    logic [7:0] o_drop_cnt;

    modport slave (
        input  i_btn_run, i_btn_clear, i_btn_mode, rx_data, rx_done, tx_busy,
        output o_run_toggle, o_clear, o_mode_toggle, tx_data, tx_start,
               o_fifo_full, o_drop_cnt
    );

    modport master (
        output i_btn_run, i_btn_clear, i_btn_mode, rx_data, rx_done, tx_busy,
        input  o_run_toggle, o_clear, o_mode_toggle, tx_data, tx_start,
               o_fifo_full, o_drop_cnt
    );
endinterface

// File: rtl/cmd_scheduler.sv
// ----------------------------------------------------------------------------
// cmd_scheduler
// Collects run/clear/mode requests from buttons and UART bytes ('r','c','m'),
// holds each in a pending flag, funnels them one per cycle into a small FIFO
// (priority UART > CLEAR > RUN > MODE) and issues them as single-cycle pulses
// separated by GAP_CYCLES idle cycles. Events that hit an already-pending,
// not-draining flag are dropped and counted (saturating at 255).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cmd_scheduler_if.slave (buttons, UART rx/tx, pulses, status)
// Parameters:
//   FIFO_DEPTH : queue entries, power of two 2..16
//   GAP_CYCLES : idle cycles between issued commands, 0..255
// Optional feature: define CMD_SCHEDULER_ECHO_EN to echo every issued command
// as its lowercase letter on the UART transmitter (waits for tx_busy low).
// ----------------------------------------------------------------------------
module cmd_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    cmd_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {CMD_RUN = 2'd0, CMD_CLEAR = 2'd1, CMD_MODE = 2'd2} cmd_t;
`ifdef CMD_SCHEDULER_ECHO_EN
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ECHO, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
`endif

    // ---------------- decode ----------------
    logic uart_ev;
    cmd_t uart_code;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        uart_ev   = 1'b0;
        uart_code = CMD_RUN;
        if (bus.rx_done) begin
            case (bus.rx_data)
                8'h72:   begin uart_ev = 1'b1; uart_code = CMD_RUN;   end
                8'h63:   begin uart_ev = 1'b1; uart_code = CMD_CLEAR; end
                8'h6D:   begin uart_ev = 1'b1; uart_code = CMD_MODE;  end
                default: ;
            endcase
        end
    end

    // ---------------- FIFO and pending flags ----------------
    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty, pop, can_push, push;
    cmd_t             push_cmd;

    logic uart_pend, clr_pend, run_pend, mode_pend;
    cmd_t uart_code_q;
    logic push_uart, push_clr, push_run, push_mode;
    logic drop_uart, drop_clr, drop_run, drop_mode;
    logic [2:0] drop_total;
    logic [8:0] drop_sum;
    logic [7:0] drop_cnt;

    state_t state;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = (state == S_IDLE) && !empty;
    // A full queue still accepts a push in the cycle its head is popped.
    assign can_push = !full || pop;

    always_comb begin
        push_uart = 1'b0;
        push_clr  = 1'b0;
        push_run  = 1'b0;
        push_mode = 1'b0;
        push_cmd  = CMD_RUN;
        if (can_push) begin
            if (uart_pend)      begin push_uart = 1'b1; push_cmd = uart_code_q; end
            else if (clr_pend)  begin push_clr  = 1'b1; push_cmd = CMD_CLEAR;   end
            else if (run_pend)  begin push_run  = 1'b1; push_cmd = CMD_RUN;     end
            else if (mode_pend) begin push_mode = 1'b1; push_cmd = CMD_MODE;    end
        end
    end
    assign push = push_uart | push_clr | push_run | push_mode;

    // An event is lost only if its flag stays occupied this cycle.
    assign drop_uart = uart_ev         & uart_pend & ~push_uart;
    assign drop_clr  = bus.i_btn_clear & clr_pend  & ~push_clr;
    assign drop_run  = bus.i_btn_run   & run_pend  & ~push_run;
    assign drop_mode = bus.i_btn_mode  & mode_pend & ~push_mode;
    assign drop_total = 3'(drop_uart) + 3'(drop_clr) + 3'(drop_run) + 3'(drop_mode);
    assign drop_sum   = {1'b0, drop_cnt} + 9'(drop_total);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_pend   <= 1'b0;
            clr_pend    <= 1'b0;
            run_pend    <= 1'b0;
            mode_pend   <= 1'b0;
            uart_code_q <= CMD_RUN;
            drop_cnt    <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            if (uart_ev && !drop_uart) begin
                uart_pend   <= 1'b1;
                uart_code_q <= uart_code;
            end else if (push_uart) begin
                uart_pend <= 1'b0;
            end
            if (bus.i_btn_clear && !drop_clr) clr_pend  <= 1'b1;
            else if (push_clr)                clr_pend  <= 1'b0;
            if (bus.i_btn_run && !drop_run)   run_pend  <= 1'b1;
            else if (push_run)                run_pend  <= 1'b0;
            if (bus.i_btn_mode && !drop_mode) mode_pend <= 1'b1;
            else if (push_mode)               mode_pend <= 1'b0;
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // NOTE: storage array has no reset; emptiness is defined by the reset pointers and count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_cmd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- issue FSM ----------------
    logic       run_q, clr_q, mode_q;
    logic [7:0] gap_cnt;

`ifdef CMD_SCHEDULER_ECHO_EN
    cmd_t       cur_cmd;
    logic       tx_start_q;
    logic [7:0] tx_data_q;

    function automatic logic [7:0] cmd_letter(input cmd_t c);
        case (c)
            CMD_RUN:   return 8'h72;
            CMD_CLEAR: return 8'h63;
            default:   return 8'h6D;
        endcase
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            run_q   <= 1'b0;
            clr_q   <= 1'b0;
            mode_q  <= 1'b0;
            gap_cnt <= 8'd0;
`ifdef CMD_SCHEDULER_ECHO_EN
            cur_cmd    <= CMD_RUN;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
`endif
        end else begin
            run_q  <= 1'b0;
            clr_q  <= 1'b0;
            mode_q <= 1'b0;
`ifdef CMD_SCHEDULER_ECHO_EN
            tx_start_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        state  <= S_ISSUE;
                        run_q  <= (fifo_mem[rd_ptr] == CMD_RUN);
                        clr_q  <= (fifo_mem[rd_ptr] == CMD_CLEAR);
                        mode_q <= (fifo_mem[rd_ptr] == CMD_MODE);
`ifdef CMD_SCHEDULER_ECHO_EN
                        cur_cmd <= fifo_mem[rd_ptr];
`endif
                    end
                end
                S_ISSUE: begin
`ifdef CMD_SCHEDULER_ECHO_EN
                    state <= S_ECHO;
`else
                    if (GAP_CYCLES == 0) begin
                        state <= S_IDLE;
                    end else begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_LAST;
                    end
`endif
                end
`ifdef CMD_SCHEDULER_ECHO_EN
                S_ECHO: begin
                    if (!bus.tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= cmd_letter(cur_cmd);
                        if (GAP_CYCLES == 0) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_LAST;
                        end
                    end
                end
`endif
                S_GAP: begin
                    if (gap_cnt == 8'd0) state   <= S_IDLE;
                    else                 gap_cnt <= gap_cnt - 8'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_run_toggle  = run_q;
    assign bus.o_clear       = clr_q;
    assign bus.o_mode_toggle = mode_q;
    assign bus.o_fifo_full   = full;
    assign bus.o_drop_cnt    = drop_cnt;
`ifdef CMD_SCHEDULER_ECHO_EN
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
`else
    logic unused_tx_busy;
    assign unused_tx_busy = bus.tx_busy;
    assign bus.tx_start   = 1'b0;
    assign bus.tx_data    = 8'h00;
`endif
endmodule

// File: tb/tb_cmd_scheduler.sv
// ----------------------------------------------------------------------------
// tb_cmd_scheduler
// Self-checking bench for cmd_scheduler: a table of single-event vectors
// followed by directed multi-cycle sequences (simultaneous events, drops,
// queue-full stall, echo back-pressure, reset mid-issue, drop saturation).
// Build with CMD_SCHEDULER_ECHO_EN defined to exercise the echo path.
// ----------------------------------------------------------------------------
module tb_cmd_scheduler;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP_CYCLES = 2;
`ifdef CMD_SCHEDULER_ECHO_EN
    localparam int ECHO_CYC = 1;
`else
    localparam int ECHO_CYC = 0;
`endif
    // Cycles from one issue pulse to the next with a backlog: ISSUE, ECHO, GAP..., IDLE.
    localparam int PERIOD = GAP_CYCLES + ECHO_CYC + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cmd_scheduler_if bus ();

    cmd_scheduler #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- output monitor ----------------
    typedef struct {
        int cyc;
        int kind;   // 1 run, 2 clear, 3 mode
    } pev_t;

    pev_t       plog [$];
    int         tx_cyc [$];
    logic [7:0] tx_dat [$];
    int         onehot_viol = 0;
    logic       full_seen = 1'b0;

    always @(negedge clk) begin
        if (int'(bus.o_run_toggle) + int'(bus.o_clear) + int'(bus.o_mode_toggle) > 1)
            onehot_viol++;
        if (bus.o_run_toggle)  plog.push_back('{cyc, 1});
        if (bus.o_clear)       plog.push_back('{cyc, 2});
        if (bus.o_mode_toggle) plog.push_back('{cyc, 3});
        if (bus.tx_start) begin
            tx_cyc.push_back(cyc);
            tx_dat.push_back(bus.tx_data);
        end
        if (bus.o_fifo_full) full_seen = 1'b1;
    end

    // ---------------- helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_ev(input string name, input int idx, input int kind, input int at);
        if (idx < plog.size()) begin
            check({name, "_kind"}, plog[idx].kind, kind);
            check({name, "_cycle"}, plog[idx].cyc, at);
        end else begin
            check({name, "_present"}, plog.size(), idx + 1);
        end
    endtask

`ifdef CMD_SCHEDULER_ECHO_EN
    task automatic check_tx(input string name, input int idx, input int data, input int at);
        if (idx < tx_cyc.size()) begin
            check({name, "_data"}, int'(tx_dat[idx]), data);
            check({name, "_cycle"}, tx_cyc[idx], at);
        end else begin
            check({name, "_present"}, tx_cyc.size(), idx + 1);
        end
    endtask
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_inputs();
        bus.i_btn_run   = 1'b0;
        bus.i_btn_clear = 1'b0;
        bus.i_btn_mode  = 1'b0;
        bus.rx_done     = 1'b0;
        bus.rx_data     = 8'h00;
    endtask

    // ---------------- single-event vectors ----------------
    typedef struct {
        logic       rxd;
        logic [7:0] rx;
        logic       run;
        logic       clr;
        logic       mode;
        int         exp_kind;    // 0 means no pulse expected
        logic [7:0] exp_letter;
    } vec_t;

    vec_t vt [8];

    int n, base, tbase, drop0, cnt;

    initial begin
        vt[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 8'h72};  // run button at cycle 10
        vt[1] = '{1'b1, 8'h72, 1'b0, 1'b0, 1'b0, 1, 8'h72};  // "r"
        vt[2] = '{1'b1, 8'h63, 1'b0, 1'b0, 1'b0, 2, 8'h63};  // "c"
        vt[3] = '{1'b1, 8'h6D, 1'b0, 1'b0, 1'b0, 3, 8'h6D};  // "m"
        vt[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2, 8'h63};  // clear button
        vt[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3, 8'h6D};  // mode button
        vt[6] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 0, 8'h00};  // "A" ignored
        vt[7] = '{1'b1, 8'h52, 1'b0, 1'b0, 1'b0, 0, 8'h00};  // "R" ignored

        clear_inputs();
        bus.tx_busy = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_run",    int'(bus.o_run_toggle),  0);
        check("rst_clear",  int'(bus.o_clear),       0);
        check("rst_mode",   int'(bus.o_mode_toggle), 0);
        check("rst_txs",    int'(bus.tx_start),      0);
        check("rst_txd",    int'(bus.tx_data),       0);
        check("rst_full",   int'(bus.o_fifo_full),   0);
        check("rst_drop",   int'(bus.o_drop_cnt),    0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table: one event from idle, pulse expected exactly 3 cycles later
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                while (cyc < 10) tick();
            end
            n     = cyc;
            base  = plog.size();
            tbase = tx_cyc.size();
            bus.rx_done     = vt[i].rxd;
            bus.rx_data     = vt[i].rx;
            bus.i_btn_run   = vt[i].run;
            bus.i_btn_clear = vt[i].clr;
            bus.i_btn_mode  = vt[i].mode;
            tick();
            clear_inputs();
            idle(14);
            if (vt[i].exp_kind == 0) begin
                check($sformatf("vec%0d_no_pulse", i), plog.size() - base, 0);
            end else begin
                check($sformatf("vec%0d_count", i), plog.size() - base, 1);
                check_ev($sformatf("vec%0d", i), base, vt[i].exp_kind, n + 3);
            end
`ifdef CMD_SCHEDULER_ECHO_EN
            if (vt[i].exp_kind == 0) begin
                check($sformatf("vec%0d_no_echo", i), tx_cyc.size() - tbase, 0);
            end else begin
                check($sformatf("vec%0d_echo_count", i), tx_cyc.size() - tbase, 1);
                check_tx($sformatf("vec%0d_echo", i), tbase, int'(vt[i].exp_letter), n + 5);
            end
`endif
        end
        check("table_drop", int'(bus.o_drop_cnt), 0);

        // UART "c" together with mode button: clear first, mode one period later
        n    = cyc;
        base = plog.size();
        bus.rx_done    = 1'b1;
        bus.rx_data    = 8'h63;
        bus.i_btn_mode = 1'b1;
        tick();
        clear_inputs();
        idle(2 * PERIOD + 8);
        check("simul_count", plog.size() - base, 2);
        check_ev("simul_first", base, 2, n + 3);
        check_ev("simul_second", base + 1, 3, n + 3 + PERIOD);
        check("simul_drop", int'(bus.o_drop_cnt), 0);

        // Mode flag starved by UART traffic: second mode press is dropped
        n    = cyc;
        base = plog.size();
        bus.rx_done = 1'b1; bus.rx_data = 8'h63; bus.i_btn_mode = 1'b1;
        tick();
        bus.rx_done = 1'b1; bus.rx_data = 8'h63; bus.i_btn_mode = 1'b1;
        tick();
        clear_inputs();
        bus.rx_done = 1'b1; bus.rx_data = 8'h63;
        tick();
        clear_inputs();
        idle(3 * PERIOD + 10);
        check("starve_count", plog.size() - base, 4);
        check_ev("starve_0", base,     2, n + 3);
        check_ev("starve_1", base + 1, 2, n + 3 + PERIOD);
        check_ev("starve_2", base + 2, 2, n + 3 + 2 * PERIOD);
        check_ev("starve_3", base + 3, 3, n + 3 + 3 * PERIOD);
        check("starve_drop", int'(bus.o_drop_cnt), 1);

        // Seven back-to-back clear presses into a 4-deep queue
        base      = plog.size();
        drop0     = int'(bus.o_drop_cnt);
        full_seen = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.i_btn_clear = 1'b1;
            tick();
        end
        clear_inputs();
        idle(7 * PERIOD + 15);
        cnt = 0;
        for (int k = base; k < plog.size(); k++) if (plog[k].kind == 2) cnt++;
        check("burst_full_seen", int'(full_seen), 1);
        check("burst_only_clear", plog.size() - base, cnt);
        check("burst_clear_plus_drop", cnt + int'(bus.o_drop_cnt) - drop0, 7);
        check("burst_full_after_drain", int'(bus.o_fifo_full), 0);

`ifdef CMD_SCHEDULER_ECHO_EN
        // Echo held off by tx_busy for 20 cycles, mode queued behind it
        n     = cyc;
        base  = plog.size();
        tbase = tx_cyc.size();
        bus.rx_done = 1'b1; bus.rx_data = 8'h72; bus.tx_busy = 1'b1;
        tick();
        clear_inputs();
        bus.i_btn_mode = 1'b1;
        tick();
        clear_inputs();
        while (cyc < n + 20) tick();
        bus.tx_busy = 1'b0;
        idle(20);
        cnt = 0;
        for (int k = tbase; k < tx_cyc.size(); k++) if (tx_cyc[k] <= n + 21) cnt++;
        check("busy_echo_once", cnt, 1);
        check_tx("busy_echo", tbase, 8'h72, n + 21);
        check_ev("busy_run", base, 1, n + 3);
        check_ev("busy_next", base + 1, 3, n + 21 + GAP_CYCLES + 1);
`endif

        // Reset while the first of three queued commands is being issued
        n = cyc;
        bus.rx_done = 1'b1; bus.rx_data = 8'h72;
        bus.i_btn_clear = 1'b1; bus.i_btn_mode = 1'b1;
        tick();
        clear_inputs();
        while (cyc < n + 3) tick();
        check("pre_rst_issue", int'(bus.o_run_toggle), 1);
        rst = 1'b1;
        base = plog.size();
        @(negedge clk);
        check("mid_rst_run",  int'(bus.o_run_toggle),  0);
        check("mid_rst_clr",  int'(bus.o_clear),       0);
        check("mid_rst_mode", int'(bus.o_mode_toggle), 0);
        check("mid_rst_full", int'(bus.o_fifo_full),   0);
        check("mid_rst_drop", int'(bus.o_drop_cnt),    0);
        tick();
        tick();
        rst = 1'b0;
        idle(20);
        check("post_rst_silent", plog.size() - base, 0);
        n    = cyc;
        base = plog.size();
        bus.i_btn_run = 1'b1;
        tick();
        clear_inputs();
        idle(8);
        check("post_rst_count", plog.size() - base, 1);
        check_ev("post_rst_run", base, 1, n + 3);

        // Flood every source until the drop counter saturates
        for (int k = 0; k < 120; k++) begin
            bus.rx_done = 1'b1; bus.rx_data = 8'h63;
            bus.i_btn_run = 1'b1; bus.i_btn_clear = 1'b1; bus.i_btn_mode = 1'b1;
            tick();
        end
        clear_inputs();
        check("sat_drop", int'(bus.o_drop_cnt), 255);
        idle(60);
        check("sat_hold", int'(bus.o_drop_cnt), 255);

        check("onehot", onehot_viol, 0);
`ifndef CMD_SCHEDULER_ECHO_EN
        check("no_tx_start", tx_cyc.size(), 0);
        check("tx_data_zero", int'(bus.tx_data), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/cmd_scheduler.md
CMD_SCHEDULER -- requirements
Module: cmd_scheduler

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning command queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2, meaning idle cycles enforced between issued commands (0..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_btn_run, input, 1 bit: single-cycle run/stop button event.
REQ-006 The block SHALL have port i_btn_clear, input, 1 bit: single-cycle clear button event.
REQ-007 The block SHALL have port i_btn_mode, input, 1 bit: single-cycle up/down button event.
REQ-008 The block SHALL have port rx_data, input, 8 bits: received UART byte.
REQ-009 The block SHALL have port rx_done, input, 1 bit: rx_data valid, single cycle.
REQ-010 The block SHALL have port tx_busy, input, 1 bit: UART transmitter busy.
REQ-011 The block SHALL have ports o_run_toggle, o_clear and o_mode_toggle, each output, 1 bit: single-cycle command pulses to the counter controller.
REQ-012 The block SHALL have ports tx_data (output, 8 bits) and tx_start (output, 1 bit): echo byte and a single-cycle send request.
REQ-013 The block SHALL have port o_fifo_full, output, 1 bit: queue full.
REQ-014 The block SHALL have port o_drop_cnt, output, 8 bits: count of dropped events, saturating.

Function
REQ-015 Decoding SHALL be: rx_done with rx_data 0x72 "r" gives RUN, 0x63 "c" gives CLEAR, 0x6D "m" gives MODE; any other byte is ignored and not counted as a drop.
REQ-016 Four pending flags SHALL exist (UART, CLEAR, RUN, MODE); the UART flag carries its decoded code, and each flag is set on the edge sampling its event.
REQ-017 An event arriving while its flag is already set and not being cleared in that cycle SHALL be dropped, and o_drop_cnt SHALL increment, saturating at 255.
REQ-018 An event arriving in the same cycle its flag is pushed SHALL re-set the flag, with no drop.
REQ-019 Per cycle, at most one pending flag SHALL be pushed into the FIFO when not full, with fixed priority UART > CLEAR > RUN > MODE.
REQ-020 When the FIFO is full, pending flags SHALL be held, not dropped.
REQ-021 The issue FSM SHALL have states IDLE, ISSUE, ECHO and GAP.
REQ-022 In IDLE with the FIFO non-empty, the FSM SHALL pop the head and go to ISSUE.
REQ-023 In ISSUE, exactly one matching output pulse SHALL be high for one cycle.
REQ-024 ISSUE SHALL go to ECHO when echo is compiled in, otherwise to GAP.
REQ-025 GAP SHALL last GAP_CYCLES cycles and then return to IDLE; with GAP_CYCLES=0, GAP SHALL be skipped and the next state is IDLE.
REQ-026 Latency SHALL be 3 cycles with the FSM in IDLE and the FIFO empty: an event in cycle N gives its pulse in cycle N+3.
REQ-027 At most one of the three command pulses SHALL be high in any cycle.
REQ-028 Issue order SHALL equal FIFO push order.
REQ-029 A simultaneous FIFO push and pop SHALL be allowed when the FIFO is full, and the count SHALL stay unchanged.

Reset
REQ-030 While rst is high, all outputs SHALL be 0, the FSM SHALL be in IDLE, the FIFO empty, all pending flags clear, and o_drop_cnt 0.
REQ-031 rst asserted mid-operation SHALL abort any pulse, echo or gap immediately, and all queued commands SHALL be discarded.

Configuration
REQ-032 With macro CMD_SCHEDULER_ECHO_EN defined, ECHO SHALL wait while tx_busy=1, then drive tx_start=1 for one cycle with tx_data equal to the issued command's lowercase letter (0x72, 0x63 or 0x6D), then go to GAP.
REQ-033 Echo SHALL apply to button-sourced commands as well as UART-sourced ones.
REQ-034 Without CMD_SCHEDULER_ECHO_EN, the ECHO state SHALL be absent, tx_start SHALL be tied to 0, tx_data to 0x00, and tx_busy ignored.

Verification
REQ-035 The bench SHALL drive an i_btn_run pulse at cycle 10 from idle and check o_run_toggle high in cycle 13 only, all other pulses 0.
REQ-036 The bench SHALL drive rx_done with rx_data 0x63 in the same cycle as i_btn_mode and check o_clear, then o_mode_toggle after the gap, with o_drop_cnt equal to 0.
REQ-037 The bench SHALL drive rx_data 0x41 with rx_done and check no pulse is issued and o_drop_cnt stays 0.
REQ-038 The bench SHALL drive i_btn_clear on 7 consecutive cycles with FIFO_DEPTH=4 and check o_fifo_full asserted, the stalled flag held, and the issued CLEAR count plus o_drop_cnt equal to 7.
REQ-039 With echo enabled and tx_busy held at 1 for 20 cycles after an "r" command, the bench SHALL check tx_start high exactly once, in the cycle after tx_busy falls, with tx_data 0x72, and the next command is not issued before that plus GAP_CYCLES.
REQ-040 The bench SHALL assert rst during ISSUE with 3 queued commands and check outputs 0 immediately and no pulses after release until a new event.
